// File: rtl/axis_unpack_arbiter_if.sv
// ---------------------------------------------------------------------------
// axis_unpack_arbiter_if
// Bundles the wide AXIS source lanes and the single arbitrated output stream
// that feeds the downstream wide-to-narrow unpacker.
//
// Signals
//   s_tvalid / s_tready / s_tlast  NUM_PORTS   per-source handshake
//   s_tdata   NUM_PORTS*AXIS_BYTES*8  source i at [i*AXIS_BYTES*8 +: AXIS_BYTES*8]
//   m_tvalid / m_tready / m_tlast  1           output handshake
//   m_tdata   AXIS_BYTES*8                     output word
//   m_tid     ID_WIDTH                         source index of the output word
//
// Modports
//   master : the arbiter's view (drives s_tready and the m_* stream)
//   slave  : the surrounding sources and unpacker
// ---------------------------------------------------------------------------
interface axis_unpack_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int AXIS_BYTES = 8,
    parameter int ID_WIDTH   = 2
);
    logic [NUM_PORTS-1:0]              s_tvalid;
    logic [NUM_PORTS-1:0]              s_tready;
    logic [NUM_PORTS-1:0]              s_tlast;
    logic [NUM_PORTS*AXIS_BYTES*8-1:0] s_tdata;

    logic                              m_tvalid;
    logic                              m_tready;
    logic                              m_tlast;
    logic [AXIS_BYTES*8-1:0]           m_tdata;
    logic [ID_WIDTH-1:0]               m_tid;

    modport master (
        input  s_tvalid, s_tlast, s_tdata, m_tready,
        output s_tready, m_tvalid, m_tlast, m_tdata, m_tid
    );

    modport slave (
        output s_tvalid, s_tlast, s_tdata, m_tready,
        input  s_tready, m_tvalid, m_tlast, m_tdata, m_tid
    );
endinterface

// File: rtl/axis_unpack_arbiter.sv
// ---------------------------------------------------------------------------
// axis_unpack_arbiter
// Packet-level round-robin arbiter sharing one downstream wide-to-narrow
// unpacker among NUM_PORTS wide AXIS sources. A source is granted for a whole
// packet (locked until tlast); its words pass through one output register
// stage and are tagged with the source index on m_tid.
//
// Ports
//   clk          clock, rising edge
//   sresetn      synchronous reset, active-low
//   port_enable  per-source grant enable (0 = never newly granted)
//   bus          axis_unpack_arbiter_if.master: source lanes and output stream
//   busy         1 while a packet is locked
// ---------------------------------------------------------------------------
module axis_unpack_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int AXIS_BYTES = 8,
    parameter int ID_WIDTH   = 2
) (
    input  logic                   clk,
    input  logic                   sresetn,
    input  logic [NUM_PORTS-1:0]   port_enable,
    axis_unpack_arbiter_if.master  bus,
    output logic                   busy
);
    localparam int DATA_WIDTH = AXIS_BYTES * 8;
    localparam int PTR_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [PTR_WIDTH-1:0] LAST_PORT = PTR_WIDTH'(NUM_PORTS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                 state;
    logic [PTR_WIDTH-1:0]   ptr;
    logic [PTR_WIDTH-1:0]   sel;
    logic [PTR_WIDTH-1:0]   winner;
    logic                   found;
    logic [NUM_PORTS-1:0]   candidates;
    logic [NUM_PORTS-1:0]   ready;
    logic                   load;
    logic [DATA_WIDTH-1:0]  words [NUM_PORTS];

    // Split the flat source bus into one word per port for clean selection.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_words
        assign words[i] = bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign candidates = bus.s_tvalid & port_enable;

    // Round-robin search starting at ptr and wrapping; the first candidate
    // encountered wins.
    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!found && candidates[PTR_WIDTH'(idx)]) begin
                found  = 1'b1;
                winner = PTR_WIDTH'(idx);
            end
        end
    end

    // Only the locked source sees ready, and only when the output register
    // is empty or draining this cycle. Held low throughout reset.
    always_comb begin
        ready = '0;
        if (sresetn && state == LOCKED) begin
            ready[sel] = !bus.m_tvalid || bus.m_tready;
        end
    end

    assign bus.s_tready = ready;
    assign load         = bus.s_tvalid[sel] && ready[sel];
    assign busy         = sresetn && (state == LOCKED);

    // Grant FSM plus output register. A load takes priority over a drain so
    // back-to-back words sustain one word per clock.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state        <= IDLE;
            ptr          <= '0;
            sel          <= '0;
            bus.m_tvalid <= 1'b0;
            bus.m_tlast  <= 1'b0;
            bus.m_tdata  <= '0;
            bus.m_tid    <= '0;
        end else begin
            if (load) begin
                bus.m_tdata  <= words[sel];
                bus.m_tlast  <= bus.s_tlast[sel];
                bus.m_tid    <= ID_WIDTH'(sel);
                bus.m_tvalid <= 1'b1;
            end else if (bus.m_tready) begin
                bus.m_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        sel   <= winner;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (load && bus.s_tlast[sel]) begin
                        state <= IDLE;
                        ptr   <= (sel == LAST_PORT) ? '0 : sel + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_unpack_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_unpack_arbiter
// Directed bench for axis_unpack_arbiter with NUM_PORTS=4, AXIS_BYTES=8.
// Each source is a small packet generator that advances on its own handshake;
// word contents encode {port, packet, word} so every output word is traceable.
// Inputs change on the falling edge; outputs are compared 1 time unit later.
// ---------------------------------------------------------------------------
module tb_axis_unpack_arbiter;
    localparam int NP = 4;
    localparam int AB = 8;
    localparam int IW = 2;
    localparam int DW = AB * 8;

    logic          clk = 1'b0;
    logic          sresetn;
    logic [NP-1:0] port_enable;
    logic          busy;

    axis_unpack_arbiter_if #(.NUM_PORTS(NP), .AXIS_BYTES(AB), .ID_WIDTH(IW)) bus ();

    axis_unpack_arbiter #(.NUM_PORTS(NP), .AXIS_BYTES(AB), .ID_WIDTH(IW)) dut (
        .clk         (clk),
        .sresetn     (sresetn),
        .port_enable (port_enable),
        .bus         (bus),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int src_len  [NP];
    int src_left [NP];
    int src_word [NP];
    int src_pkt  [NP];

    logic          rst_n_next;
    logic [NP-1:0] en_next;
    logic          mready_next;

    int bp_w [1:14] = '{-1, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, -1};
    int fair_tid [6] = '{0, 1, 2, 3, 0, 1};
    int fair_pkt [6] = '{0, 0, 0, 0, 1, 1};

    function automatic logic [63:0] word_of(input int p, input int k, input int w);
        return 64'hD000_0000_0000_0000 | (64'(p) << 16) | (64'(k) << 8) | 64'(w);
    endfunction

    task automatic configSource(input int p, input int len, input int npk);
        src_len[p]  = len;
        src_left[p] = npk;
        src_word[p] = 0;
        src_pkt[p]  = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            bus.s_tvalid[i]            = (src_left[i] > 0);
            bus.s_tlast[i]             = (src_word[i] == src_len[i] - 1);
            bus.s_tdata[i*DW +: DW]    = word_of(i, src_pkt[i], src_word[i]);
        end
    endtask

    // Advance one clock: handshakes seen now take effect at the coming edge,
    // then the staged control values and next source words are applied.
    task automatic applyStimulus();
        logic [NP-1:0] hs;
        hs = bus.s_tvalid & bus.s_tready;
        @(negedge clk);
        for (int i = 0; i < NP; i++) begin
            if (hs[i]) begin
                if (src_word[i] == src_len[i] - 1) begin
                    src_word[i] = 0;
                    src_pkt[i]  = src_pkt[i] + 1;
                    src_left[i] = src_left[i] - 1;
                end else begin
                    src_word[i] = src_word[i] + 1;
                end
            end
        end
        sresetn      = rst_n_next;
        port_enable  = en_next;
        bus.m_tready = mready_next;
        drive();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Arbitration cycle followed by a two-word packet from port p.
    task automatic expectPacket(input int p, input int k);
        logic [NP-1:0] onehot;
        onehot = 4'b0001 << p;
        applyStimulus();
        checkOutput("grant_busy",  64'(busy), 64'd1);
        checkOutput("grant_ready", 64'(bus.s_tready), 64'(onehot));
        checkOutput("grant_gap",   64'(bus.m_tvalid), 64'd0);
        applyStimulus();
        checkOutput("w0_valid", 64'(bus.m_tvalid), 64'd1);
        checkOutput("w0_data",  bus.m_tdata, word_of(p, k, 0));
        checkOutput("w0_tid",   64'(bus.m_tid), 64'(p));
        checkOutput("w0_last",  64'(bus.m_tlast), 64'd0);
        applyStimulus();
        checkOutput("w1_data",  bus.m_tdata, word_of(p, k, 1));
        checkOutput("w1_tid",   64'(bus.m_tid), 64'(p));
        checkOutput("w1_last",  64'(bus.m_tlast), 64'd1);
        checkOutput("w1_busy",  64'(busy), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin
            src_len[i] = 0; src_left[i] = 0; src_word[i] = 0; src_pkt[i] = 0;
        end

        // Reset held with every source valid
        $display("[TB] reset hold");
        rst_n_next = 1'b0; en_next = 4'b1111; mready_next = 1'b1;
        sresetn = 1'b0; port_enable = 4'b1111; bus.m_tready = 1'b1;
        for (int i = 0; i < NP; i++) configSource(i, 2, 1);
        drive();
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            checkOutput("rst_valid", 64'(bus.m_tvalid), 64'd0);
            checkOutput("rst_ready", 64'(bus.s_tready), 64'd0);
            checkOutput("rst_busy",  64'(busy), 64'd0);
            checkOutput("rst_tid",   64'(bus.m_tid), 64'd0);
        end
        for (int i = 0; i < NP; i++) src_left[i] = 0;

        // Single source: port 2, three words
        $display("[TB] single source");
        rst_n_next = 1'b1;
        configSource(2, 3, 1);
        applyStimulus();
        checkOutput("s_idle_busy",  64'(busy), 64'd0);
        checkOutput("s_idle_ready", 64'(bus.s_tready), 64'd0);
        applyStimulus();
        checkOutput("s_grant_busy",  64'(busy), 64'd1);
        checkOutput("s_grant_ready", 64'(bus.s_tready), 64'b0100);
        checkOutput("s_grant_valid", 64'(bus.m_tvalid), 64'd0);
        applyStimulus();
        checkOutput("s_a0_data",  bus.m_tdata, word_of(2, 0, 0));
        checkOutput("s_a0_tid",   64'(bus.m_tid), 64'd2);
        checkOutput("s_a0_last",  64'(bus.m_tlast), 64'd0);
        checkOutput("s_a0_valid", 64'(bus.m_tvalid), 64'd1);
        applyStimulus();
        checkOutput("s_a1_data",  bus.m_tdata, word_of(2, 0, 1));
        checkOutput("s_a1_last",  64'(bus.m_tlast), 64'd0);
        applyStimulus();
        checkOutput("s_a2_data",  bus.m_tdata, word_of(2, 0, 2));
        checkOutput("s_a2_last",  64'(bus.m_tlast), 64'd1);
        checkOutput("s_a2_busy",  64'(busy), 64'd0);
        applyStimulus();
        checkOutput("s_drained", 64'(bus.m_tvalid), 64'd0);

        // Fairness: reset to ptr=0, all ports with back-to-back packets
        $display("[TB] fairness");
        configSource(0, 2, 2); configSource(1, 2, 2);
        configSource(2, 2, 1); configSource(3, 2, 1);
        rst_n_next = 1'b0;
        applyStimulus();
        checkOutput("f_rst_ready", 64'(bus.s_tready), 64'd0);
        rst_n_next = 1'b1;
        applyStimulus();
        checkOutput("f_idle_valid", 64'(bus.m_tvalid), 64'd0);
        checkOutput("f_idle_busy",  64'(busy), 64'd0);
        for (int n = 0; n < 6; n++) expectPacket(fair_tid[n], fair_pkt[n]);
        applyStimulus();
        checkOutput("f_end_busy",  64'(busy), 64'd0);
        checkOutput("f_end_valid", 64'(bus.m_tvalid), 64'd0);

        // Backpressure: port 1, four words, m_tready 1,0,0,1,...
        $display("[TB] backpressure");
        configSource(1, 4, 1);
        applyStimulus();
        checkOutput("b_idle_busy", 64'(busy), 64'd0);
        for (int k = 1; k <= 14; k++) begin
            mready_next = (k % 3 == 1);
            applyStimulus();
            if (bp_w[k] < 0) begin
                checkOutput("b_empty", 64'(bus.m_tvalid), 64'd0);
            end else begin
                checkOutput("b_valid", 64'(bus.m_tvalid), 64'd1);
                checkOutput("b_data",  bus.m_tdata, word_of(1, 0, bp_w[k]));
                checkOutput("b_last",  64'(bus.m_tlast), 64'(bp_w[k] == 3));
                checkOutput("b_tid",   64'(bus.m_tid), 64'd1);
            end
            if (k <= 10) begin
                checkOutput("b_ready", 64'(bus.s_tready), (k % 3 == 1) ? 64'b0010 : 64'd0);
            end
        end
        mready_next = 1'b1;

        // Enable mask 1011 with ptr=2; port 3 disabled mid-packet
        $display("[TB] enable mask");
        for (int i = 0; i < NP; i++) configSource(i, 2, 1);
        en_next = 4'b1011;
        applyStimulus();
        checkOutput("e_idle_busy", 64'(busy), 64'd0);
        en_next = 4'b0011;
        expectPacket(3, 0);
        expectPacket(0, 0);
        expectPacket(1, 0);
        applyStimulus();
        checkOutput("e_end_busy",  64'(busy), 64'd0);
        checkOutput("e_end_ready", 64'(bus.s_tready), 64'd0);
        applyStimulus();
        checkOutput("e_no_port2", 64'(busy), 64'd0);
        src_left[2] = 0;
        en_next = 4'b1111;

        // Reset after two of five words from port 0
        $display("[TB] reset mid-packet");
        configSource(0, 5, 1);
        applyStimulus();
        applyStimulus();
        checkOutput("r_grant_ready", 64'(bus.s_tready), 64'b0001);
        applyStimulus();
        checkOutput("r_w0_data", bus.m_tdata, word_of(0, 0, 0));
        rst_n_next = 1'b0;
        applyStimulus();
        checkOutput("r_w1_data",  bus.m_tdata, word_of(0, 0, 1));
        checkOutput("r_in_ready", 64'(bus.s_tready), 64'd0);
        checkOutput("r_in_busy",  64'(busy), 64'd0);
        configSource(3, 1, 1);
        rst_n_next = 1'b1;
        applyStimulus();
        checkOutput("r_post_valid", 64'(bus.m_tvalid), 64'd0);
        checkOutput("r_post_data",  bus.m_tdata, 64'd0);
        checkOutput("r_post_busy",  64'(busy), 64'd0);
        applyStimulus();
        checkOutput("r_regrant_ready", 64'(bus.s_tready), 64'b0001);
        checkOutput("r_regrant_valid", 64'(bus.m_tvalid), 64'd0);
        applyStimulus();
        checkOutput("r_w2_data", bus.m_tdata, word_of(0, 0, 2));
        checkOutput("r_w2_tid",  64'(bus.m_tid), 64'd0);
        applyStimulus();
        checkOutput("r_w3_data", bus.m_tdata, word_of(0, 0, 3));
        applyStimulus();
        checkOutput("r_w4_data", bus.m_tdata, word_of(0, 0, 4));
        checkOutput("r_w4_last", 64'(bus.m_tlast), 64'd1);
        applyStimulus();
        checkOutput("r_p3_ready", 64'(bus.s_tready), 64'b1000);
        applyStimulus();
        checkOutput("r_p3_data", bus.m_tdata, word_of(3, 0, 0));
        checkOutput("r_p3_tid",  64'(bus.m_tid), 64'd3);
        checkOutput("r_p3_last", 64'(bus.m_tlast), 64'd1);
        applyStimulus();
        checkOutput("r_end_valid", 64'(bus.m_tvalid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
